// File: rtl/mmio_responder_if.sv
// MEM-stage data bus between the pipeline (master) and the MMIO responder (slave).
interface mmio_responder_if;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        MemRead;
  logic        MemWrite;
  logic        hit;
  logic [63:0] read_data;

  modport master (output address, write_data, MemRead, MemWrite, input hit, read_data);
  modport slave  (input address, write_data, MemRead, MemWrite, output hit, read_data);
endinterface

// File: rtl/mmio_responder.sv
// MMIO target: LED register, debounced switches, W1C change flag, cycle counter.
// Define MMIO_CYCLE_COUNTER_EN to implement the CYCLES register at offset 0x18.
module mmio_responder #(
  parameter logic [63:0] BASE_ADDR       = 64'h0000_0000_0000_1000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  mmio_responder_if.slave   bus,
  input  logic [17:0]       switches,
  output logic [26:0]       leds,
  output logic              sw_changed
);
  localparam int unsigned     CW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] REG_LED  = 2'd0;
  localparam logic [1:0] REG_SW   = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_CYC  = 2'd3;

  logic       aligned, wr, rd;
  logic [1:0] idx;

  assign bus.hit = (bus.address[63:5] == BASE_ADDR[63:5]);
  assign aligned = (bus.address[2:0] == 3'd0);
  assign idx     = bus.address[4:3];
  assign wr      = bus.hit && aligned && bus.MemWrite;
  assign rd      = bus.hit && aligned && bus.MemRead;

  // Switch path: 2-flop synchroniser, then count consecutive samples differing from stable.
  logic [17:0]   sync1, sync, stable;
  logic [CW-1:0] db_cnt;
  logic          accept;

  assign accept = (sync != stable) && (db_cnt == DB_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= '0;
      sync   <= '0;
      stable <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= switches;
      sync  <= sync1;
      if (sync == stable || accept) db_cnt <= '0;
      else                          db_cnt <= db_cnt + 1'b1;
      if (accept) stable <= sync;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                     leds <= '0;
    else if (wr && idx == REG_LED) leds <= bus.write_data[26:0];
  end

  // A debounce acceptance beats a simultaneous W1C clear.
  always_ff @(posedge clock) begin
    if (reset)                                          sw_changed <= 1'b0;
    else if (accept)                                    sw_changed <= 1'b1;
    else if (wr && idx == REG_STAT && bus.write_data[0]) sw_changed <= 1'b0;
  end

  logic [63:0] cycles;
`ifdef MMIO_CYCLE_COUNTER_EN
  // A load takes effect as if the loaded value had already counted once.
  always_ff @(posedge clock) begin
    if (reset)                     cycles <= '0;
    else if (wr && idx == REG_CYC) cycles <= bus.write_data + 64'd1;
    else                           cycles <= cycles + 64'd1;
  end
`else
  logic unused_wdata;
  assign cycles       = '0;
  assign unused_wdata = ^bus.write_data[63:27];
`endif

  always_comb begin
    bus.read_data = '0;
    if (rd) begin
      case (idx)
        REG_LED:  bus.read_data = {37'd0, leds};
        REG_SW:   bus.read_data = {46'd0, stable};
        REG_STAT: bus.read_data = {63'd0, sw_changed};
        default:  bus.read_data = cycles;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios plus a randomized run against a window-based model.
module tb_mmio_responder;
  localparam logic [63:0] BASE = 64'h0000_0000_0000_1000;
  localparam int DB = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] switches = '0;
  logic [26:0] leds;
  logic        sw_changed;
  int          n_checks = 0;
  int          n_fail = 0;

  mmio_responder_if bus();

  mmio_responder #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .switches(switches), .leds(leds), .sw_changed(sw_changed)
  );

  always #5 clock = ~clock;

  // Reference model: a switch value is accepted once the last DB synchronised samples,
  // all taken since the previous acceptance/reset, differ from the stable value.
  logic [26:0] m_leds;
  logic [17:0] m_stable, m_s1, m_s2;
  logic [17:0] m_win [0:DB-2];
  logic        m_chg;
  logic [63:0] m_cyc;
  int          m_age;

  function automatic logic win_ok();
    if (m_age < DB - 1 || m_s2 == m_stable) return 1'b0;
    for (int i = 0; i < DB - 1; i++) if (m_win[i] == m_stable) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic wr_to(input logic [63:0] off);
    return bus.MemWrite === 1'b1 && bus.address == BASE + off;
  endfunction

  function automatic logic [63:0] exp_read();
    if (bus.MemRead !== 1'b1) return 64'd0;
    if (bus.address == BASE)         return {37'd0, m_leds};
    if (bus.address == BASE + 8)     return {46'd0, m_stable};
    if (bus.address == BASE + 16)    return {63'd0, m_chg};
`ifdef MMIO_CYCLE_COUNTER_EN
    if (bus.address == BASE + 24)    return m_cyc;
`endif
    return 64'd0;
  endfunction

  function automatic logic exp_hit();
    return bus.address >= BASE && bus.address <= BASE + 31;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_leds <= '0; m_stable <= '0; m_s1 <= '0; m_s2 <= '0;
      m_chg <= 1'b0; m_cyc <= '0; m_age <= 0;
      for (int i = 0; i < DB - 1; i++) m_win[i] <= '0;
    end else begin
      m_s1 <= switches;
      m_s2 <= m_s1;
      m_win[0] <= m_s2;
      for (int i = 1; i < DB - 1; i++) m_win[i] <= m_win[i-1];
      if (win_ok()) begin m_stable <= m_s2; m_age <= 0; end
      else if (m_age < DB) m_age <= m_age + 1;
      if (win_ok()) m_chg <= 1'b1;
      else if (wr_to(16) && bus.write_data[0]) m_chg <= 1'b0;
      if (wr_to(0)) m_leds <= bus.write_data[26:0];
      m_cyc <= wr_to(24) ? bus.write_data + 64'd1 : m_cyc + 64'd1;
    end
  end

  // Applies one bus cycle at the falling edge and settles for checking.
  task automatic drive(input logic [63:0] a, input logic [63:0] d, input logic r, input logic w);
    @(negedge clock);
    bus.address = a; bus.write_data = d; bus.MemRead = r; bus.MemWrite = w;
    #1;
  endtask

  task automatic idle();
    drive(BASE + 64'h100, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [63:0] offs [3];
    offs[0] = 64'h00; offs[1] = 64'h08; offs[2] = 64'h10;
    reset = 1'b1; switches = '0;
    repeat (3) idle();
    reset = 1'b0;
    n_checks++; if (leds !== 27'd0) begin n_fail++; $display("FAIL reset_leds got %h exp 0", leds); end
    n_checks++; if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL reset_flag got %b exp 0", sw_changed); end
    for (int i = 0; i < 3; i++) begin
      drive(BASE + offs[i], 64'd0, 1'b1, 1'b0);
      n_checks++; if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL reset_hit off %h got %b exp 1", offs[i], bus.hit); end
      n_checks++; if (bus.read_data !== 64'd0) begin n_fail++; $display("FAIL reset_read off %h got %h exp 0", offs[i], bus.read_data); end
    end
  endtask

  task automatic test_led();
    drive(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    drive(BASE, 64'd0, 1'b1, 1'b0);
    n_checks++; if (leds !== 27'h7FF_FFFF) begin n_fail++; $display("FAIL led_out got %h exp 7ffffff", leds); end
    n_checks++; if (bus.read_data !== 64'h0000_0000_07FF_FFFF) begin n_fail++; $display("FAIL led_read got %h exp 7ffffff", bus.read_data); end
    drive(BASE + 4, 64'h123, 1'b1, 1'b1);
    n_checks++; if (bus.read_data !== 64'd0) begin n_fail++; $display("FAIL misaligned_read got %h exp 0", bus.read_data); end
    idle();
    n_checks++; if (leds !== 27'h7FF_FFFF) begin n_fail++; $display("FAIL misaligned_write got %h exp 7ffffff", leds); end
    drive(BASE, 64'h5, 1'b1, 1'b1);
    n_checks++; if (bus.read_data !== 64'h07FF_FFFF) begin n_fail++; $display("FAIL rw_same_cycle got %h exp 7ffffff", bus.read_data); end
    drive(BASE, 64'd0, 1'b1, 1'b0);
    n_checks++; if (bus.read_data !== 64'h5) begin n_fail++; $display("FAIL rw_after got %h exp 5", bus.read_data); end
  endtask

  task automatic test_debounce();
    drive(BASE + 8, 64'd0, 1'b1, 1'b0);
    switches = 18'h2A5A5;
    for (int k = 1; k <= 20; k++) begin
      logic [63:0] e;
      drive(BASE + 8, 64'd0, 1'b1, 1'b0);
      e = (k < 2 + DB) ? 64'd0 : 64'h2A5A5;
      n_checks++; if (bus.read_data !== e) begin n_fail++; $display("FAIL debounce_cycle%0d got %h exp %h", k, bus.read_data, e); end
    end
    n_checks++; if (sw_changed !== 1'b1) begin n_fail++; $display("FAIL debounce_flag got %b exp 1", sw_changed); end
  endtask

  task automatic test_pulse();
    drive(BASE + 16, 64'd1, 1'b0, 1'b1);
    drive(BASE + 16, 64'd0, 1'b1, 1'b0);
    n_checks++; if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL w1c_clear got %b exp 0", sw_changed); end
    n_checks++; if (bus.read_data !== 64'd0) begin n_fail++; $display("FAIL w1c_read got %h exp 0", bus.read_data); end
    switches = 18'h155AA;
    repeat (5) idle();
    switches = 18'h2A5A5;
    repeat (25) begin
      drive(BASE + 8, 64'd0, 1'b1, 1'b0);
      n_checks++; if (bus.read_data !== 64'h2A5A5) begin n_fail++; $display("FAIL pulse_sw got %h exp 2a5a5", bus.read_data); end
    end
    n_checks++; if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL pulse_flag got %b exp 0", sw_changed); end
  endtask

  task automatic test_w1c_collision();
    idle();
    switches = 18'h0;
    repeat (DB) idle();
    drive(BASE + 16, 64'd1, 1'b0, 1'b1);
    n_checks++; if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL collide_pre got %b exp 0", sw_changed); end
    drive(BASE + 16, 64'd0, 1'b1, 1'b0);
    n_checks++; if (sw_changed !== 1'b1) begin n_fail++; $display("FAIL collide_set_wins got %b exp 1", sw_changed); end
    n_checks++; if (bus.read_data !== 64'd1) begin n_fail++; $display("FAIL collide_read got %h exp 1", bus.read_data); end
    drive(BASE + 16, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    idle();
    n_checks++; if (sw_changed !== 1'b1) begin n_fail++; $display("FAIL w1c_bit0_zero got %b exp 1", sw_changed); end
    drive(BASE + 16, 64'd1, 1'b0, 1'b1);
    idle();
    n_checks++; if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL w1c_second got %b exp 0", sw_changed); end
  endtask

  task automatic test_cycles();
    logic [63:0] e [3];
`ifdef MMIO_CYCLE_COUNTER_EN
    e[0] = 64'hFFFF_FFFF_FFFF_FFFF; e[1] = 64'd0; e[2] = 64'd1;
`else
    e[0] = 64'd0; e[1] = 64'd0; e[2] = 64'd0;
`endif
    drive(BASE + 24, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(BASE + 24, 64'd0, 1'b1, 1'b0);
      n_checks++; if (bus.read_data !== e[i]) begin n_fail++; $display("FAIL cycles_read%0d got %h exp %h", i, bus.read_data, e[i]); end
    end
  endtask

  task automatic test_miss();
    logic [63:0] addrs [2];
    addrs[0] = BASE + 64'h20; addrs[1] = BASE - 64'h8;
    for (int i = 0; i < 2; i++) begin
      drive(addrs[i], 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      n_checks++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit %h got %b exp 0", addrs[i], bus.hit); end
      n_checks++; if (bus.read_data !== 64'd0) begin n_fail++; $display("FAIL miss_read %h got %h exp 0", addrs[i], bus.read_data); end
    end
    drive(BASE, 64'd0, 1'b1, 1'b0);
    n_checks++; if (bus.read_data !== 64'h5) begin n_fail++; $display("FAIL miss_led got %h exp 5", bus.read_data); end
  endtask

  task automatic test_random();
    logic [63:0] a, d;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1: a = BASE + 64'({$urandom_range(0, 3), 3'b000});
        2:    a = BASE + 64'($urandom_range(0, 31));
        3:    a = BASE + 64'h20 + 64'($urandom_range(0, 7) * 8);
        4:    a = BASE - 64'($urandom_range(1, 4) * 8);
        default: a = {$urandom, $urandom};
      endcase
      d = {$urandom, $urandom};
      if ($urandom_range(0, 24) == 0) switches = 18'($urandom);
      reset = (n == 200) ? 1'b1 : 1'b0;
      drive(a, d, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      n_checks++; if (bus.hit !== exp_hit()) begin n_fail++; $display("FAIL rand_hit @%h got %b exp %b", a, bus.hit, exp_hit()); end
      n_checks++; if (bus.read_data !== exp_read()) begin n_fail++; $display("FAIL rand_read @%h got %h exp %h", a, bus.read_data, exp_read()); end
      n_checks++; if (leds !== m_leds) begin n_fail++; $display("FAIL rand_leds got %h exp %h", leds, m_leds); end
      n_checks++; if (sw_changed !== m_chg) begin n_fail++; $display("FAIL rand_flag got %b exp %b", sw_changed, m_chg); end
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.address = BASE + 64'h100; bus.write_data = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    test_reset();
    test_led();
    test_debounce();
    test_pulse();
    test_w1c_collision();
    test_cycles();
    test_miss();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
Memory-mapped I/O responder on the CPU MEM-stage data bus. The pipeline's memory stage is the initiator and this block is the target.
- Decodes an address window and services MemRead/MemWrite to the LED output register, the debounced switch inputs, a switch-change status flag and a free-running cycle counter.
- Read data is returned in the same cycle, so the MEM/WB register captures it.
- Owns all switch synchronisation and debounce state.

Parameters:
BASE_ADDR, 64'h0000_0000_0000_1000, byte address of the MMIO window (bits [4:0] must be 0)
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a switch change (min 2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
address  input  64  byte address from EX/MEM ALU result
write_data  input  64  store data from EX/MEM
MemRead  input  1  load request this cycle
MemWrite  input  1  store request this cycle
switches  input  18  raw asynchronous board switches
hit  output  1  address falls in window [BASE_ADDR, BASE_ADDR+0x1F]
read_data  output  64  load data, combinational
leds  output  27  LED register
sw_changed  output  1  sticky switch-change flag

Behaviour:
Interface:
- One clock, named `clock`. Reset is synchronous and active-high, named `reset`.
- All state updates occur on the rising edge of `clock`.

Reset:
- leds=0, sw_changed=0, cycle counter=0, both synchroniser stages=0, stable switch value=0, debounce counter=0.
- read_data is 0 whenever MemRead=0 or hit=0.

Decode:
- hit = (address[63:5] == BASE_ADDR[63:5]).
- Offset = address[4:0].
- An offset with address[2:0] != 0 is misaligned: read returns 0 and write is ignored.

Register map:
- 0x00 LED: R/W.
  - Write: leds <= write_data[26:0].
  - Read: zero-extended leds.
- 0x08 SWITCH: RO, zero-extended stable switch value. Writes are ignored.
- 0x10 STATUS: bit0 = sw_changed.
  - Write with write_data[0]=1 clears the flag (W1C).
  - Other bits read 0.
- 0x18 CYCLES: 64-bit counter.
  - Increments every cycle and wraps from 2^64-1 to 0.
  - Write loads write_data; the next cycle reads write_data+1.

Timing:
- Write effects are visible on outputs and on reads in the cycle after the write edge.
- Read in the same cycle as a write to the same register returns the pre-write value.
- MemRead and MemWrite both high: the write is performed, and read_data still reflects the pre-write value.
- hit=0: no state change from the bus.

Switch path:
- 2-flop synchroniser produces sync.
- If sync == stable: debounce counter <= 0.
- Otherwise the counter increments.
- When the counter is at DEBOUNCE_CYCLES-1 and sync != stable:
  - stable <= sync, counter <= 0, sw_changed <= 1.
- Any glitch that returns sync to stable before acceptance resets the counter.
- Latency from a stable raw change to the SWITCH register update: 2 + DEBOUNCE_CYCLES cycles.
- A set event and a W1C clear in the same cycle: set wins, flag stays 1.

Reset mid-operation:
- Reset has priority over all updates.
- A pending debounce is discarded and sw_changed is cleared.

Optional Feature:
MMIO_CYCLE_COUNTER_EN
- Defined: CYCLES register at 0x18 is implemented as described.
- Undefined: counter logic is removed, 0x18 reads 0, and writes to 0x18 are ignored.
- All other registers are unchanged in both builds.

Test Plan:
- Reset, then MemRead at BASE+0x00/0x08/0x10 -> read_data=0 for each; leds=0; sw_changed=0.
- MemWrite BASE+0x00 with data 64'hFFFF_FFFF_FFFF_FFFF, then MemRead BASE+0x00 -> leds=27'h7FF_FFFF next cycle; read returns 64'h0000_0000_07FF_FFFF. Write at BASE+0x04 -> leds unchanged.
- switches 0 -> 18'h2A5A5 held -> SWITCH reads 0 up to and including cycle 2+DEBOUNCE_CYCLES-1 (17), reads 18'h2A5A5 from cycle 18; sw_changed=1.
  - Repeat with a 5-cycle pulse -> SWITCH unchanged, sw_changed stays 0.
- sw_changed=1, write BASE+0x10 data 1 -> flag 0 next cycle.
  - Arrange the W1C write on the debounce-acceptance cycle -> flag remains 1.
- (MMIO_CYCLE_COUNTER_EN) write BASE+0x18 data 64'hFFFF_FFFF_FFFF_FFFE -> consecutive reads return ...FFFF, then 0, then 1.
  - Without the macro, the same sequence reads 0.
- MemRead at address BASE+0x20 and at BASE-8 -> hit=0, read_data=0, no state change on a simultaneous MemWrite.
